// File: rtl/lcd_function_selector.sv
// lcd_function_selector: debounced NEXT/PREV buttons step a one-hot LCD function select word
module lcd_function_selector #(
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20,
    parameter int NUM_FUNC  = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_next_n,
    input  logic       key_prev_n,
    output logic [9:0] function_select,
    output logic [3:0] sel_index,
    output logic       sel_changed
);
    localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CYCLES - 1);
    localparam logic [3:0]      IDX_MAX = 4'(NUM_FUNC);
    logic [1:0]            sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d, press_q, press_d;
    logic [1:0][DB_W-1:0]  cnt_q, cnt_d;
    logic [3:0]            idx_q, idx_d;
    logic [9:0]            fsel_q, fsel_d;
    logic                  chg_q, chg_d;
    // Synchronise both buttons (bit 0 = NEXT, bit 1 = PREV), debounce, and flag falling edges
    always_comb begin
        sync1_d = {key_prev_n, key_next_n};
        sync2_d = sync1_q;
        for (int i = 0; i < 2; i++) begin
            db_d[i]  = (sync2_q[i] != db_q[i] && cnt_q[i] == CNT_MAX) ? sync2_q[i] : db_q[i];
            cnt_d[i] = (sync2_q[i] == db_q[i] || cnt_q[i] == CNT_MAX) ? '0 : cnt_q[i] + 1'b1;
        end
        press_d = db_q & ~db_d;
    end
    // Step the index on a lone press event; coincident presses cancel out
    always_comb begin
        idx_d  = press_q == 2'b01 ? (idx_q == IDX_MAX ? 4'd0 : idx_q + 4'd1)
               : press_q == 2'b10 ? (idx_q == 4'd0 ? IDX_MAX : idx_q - 4'd1)
               : idx_q;
        fsel_d = idx_d == 4'd0 ? 10'd0 : 10'd1 << (idx_d - 4'd1);
        chg_d  = idx_d != idx_q;
    end
    // State registers; buttons reset to the released level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            db_q    <= 2'b11;
            cnt_q   <= '0;
            press_q <= 2'b00;
            idx_q   <= 4'd0;
            fsel_q  <= 10'd0;
            chg_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            idx_q   <= idx_d;
            fsel_q  <= fsel_d;
            chg_q   <= chg_d;
        end
    end
    assign function_select = fsel_q;
    assign sel_index       = idx_q;
    assign sel_changed     = chg_q;
endmodule

// File: tb/tb_lcd_function_selector.sv
// tb_lcd_function_selector: directed button stimulus checked against a behavioural model
module tb_lcd_function_selector;
    localparam int DB = 8;
    localparam int NF = 9;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_next_n = 1'b1;
    logic       key_prev_n = 1'b1;
    logic [9:0] function_select;
    logic [3:0] sel_index;
    logic       sel_changed;
    int n_cmp = 0;
    int n_bad = 0;

    lcd_function_selector #(.DB_CYCLES(DB), .DB_W(4), .NUM_FUNC(NF)) dut (
        .clk(clk), .rst_n(rst_n), .key_next_n(key_next_n), .key_prev_n(key_prev_n),
        .function_select(function_select), .sel_index(sel_index), .sel_changed(sel_changed)
    );

    always #5 clk = ~clk;

    // Model: pins reach the debouncer two edges late; a level is accepted once it has
    // differed from the accepted level for DB consecutive edges; an accepted fall is a
    // press that moves the index on the following edge.
    int      m_idx;
    bit      m_chg;
    bit [1:0] m_d1, m_d2, m_db, m_ev;
    int      m_run [2];

    initial forever begin
        int old;
        bit [1:0] ev_new;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_idx = 0; m_chg = 0; m_d1 = 2'b11; m_d2 = 2'b11; m_db = 2'b11; m_ev = 2'b00;
            m_run[0] = 0; m_run[1] = 0;
        end else begin
            old = m_idx;
            ev_new = 2'b00;
            if (m_ev == 2'b01) m_idx = (m_idx == NF) ? 0 : m_idx + 1;
            else if (m_ev == 2'b10) m_idx = (m_idx == 0) ? NF : m_idx - 1;
            m_chg = (m_idx != old);
            for (int i = 0; i < 2; i++) begin
                if (m_d2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_db[i] = m_d2[i];
                        m_run[i] = 0;
                        ev_new[i] = ~m_db[i];
                    end
                end else m_run[i] = 0;
            end
            m_ev = ev_new;
            m_d2 = m_d1;
            m_d1 = {key_prev_n, key_next_n};
        end
    end

    function automatic logic [9:0] onehot(input int i);
        return i == 0 ? 10'd0 : 10'd1 << (i - 1);
    endfunction

    task automatic check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("fsel", function_select, onehot(m_idx));
            check("idx", sel_index, m_idx);
            check("chg", sel_changed, m_chg);
        end
    end

    task automatic hold(input bit [1:0] which, input int n);
        @(negedge clk);
        if (which[0]) key_next_n = 1'b0;
        if (which[1]) key_prev_n = 1'b0;
        repeat (n) @(negedge clk);
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
    endtask

    initial begin
        idle(3);
        rst_n = 1'b1;
        idle(100);
        check("lit_reset_idx", sel_index, 0);
        check("lit_reset_fsel", function_select, 10'h000);

        @(negedge clk);
        key_next_n = 1'b0;
        repeat (DB + 2) @(posedge clk);
        #1 check("lit_lat_before", sel_index, 0);
        @(posedge clk);
        #1 check("lit_lat_fsel", function_select, 10'h001);
        check("lit_lat_idx", sel_index, 1);
        check("lit_lat_chg", sel_changed, 1);
        @(posedge clk);
        #1 check("lit_lat_chg_once", sel_changed, 0);
        idle(40);
        key_next_n = 1'b1;
        idle(30);
        check("lit_release_idx", sel_index, 1);

        hold(2'b01, 5); hold(2'b00, 1); hold(2'b01, 5);
        idle(30);
        check("lit_bounce_idx", sel_index, 1);
        hold(2'b01, 20);
        idle(30);
        check("lit_after_bounce_idx", sel_index, 2);

        do_reset();
        idle(5);
        hold(2'b10, 20); idle(20);
        check("lit_prev_wrap_idx", sel_index, 9);
        check("lit_prev_wrap_fsel", function_select, 10'h100);
        hold(2'b01, 20); idle(20);
        check("lit_next_wrap_idx", sel_index, 0);
        check("lit_next_wrap_fsel", function_select, 10'h000);

        hold(2'b11, 20); idle(20);
        check("lit_both_idx", sel_index, 0);

        repeat (3) begin hold(2'b01, 12); idle(15); end
        check("lit_idx3", sel_index, 3);
        @(negedge clk);
        key_next_n = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("lit_async_idx", sel_index, 0);
        check("lit_async_fsel", function_select, 10'h000);
        check("lit_async_chg", sel_changed, 0);
        idle(2);
        rst_n = 1'b1;
        repeat (DB + 2) @(posedge clk);
        #1 check("lit_postrst_before", sel_index, 0);
        @(posedge clk);
        #1 check("lit_postrst_idx", sel_index, 1);
        check("lit_postrst_chg", sel_changed, 1);
        idle(5);
        key_next_n = 1'b1;
        idle(20);
        check("lit_final_idx", sel_index, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
